idli_ex_seq_m: RTL and testbench

// Sequences nibble-serial execution in the EX stage. Each 16b op runs as four 4b nibbles, LSB first.

---
 rtl/idli_ex_seq_m.sv | 111 +++++++++++
 tb/tb_idli_ex_seq_m.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/idli_ex_seq_m.sv
// Nibble-serial EX sequencer: runs each 16b op as N_NIB nibbles, LSB first,
// chaining ALU carry, stalling on missing immediate nibbles and aborting on flush.
module idli_ex_seq_m #(
    parameter int N_NIB = 4,
    localparam int CTR_W = $clog2(N_NIB)
) (
    input  logic             i_ex_gck,
    input  logic             i_ex_rst_n,
    input  logic             i_seq_op_vld,
    output logic             o_seq_op_acp,
    input  logic             i_seq_imm_req,
    input  logic             i_seq_wr_en,
    input  logic             i_seq_cin_init,
    input  logic             i_seq_imm_vld,
    input  logic             i_seq_alu_cout,
    input  logic             i_seq_flush,
    output logic             o_seq_busy,
    output logic [CTR_W-1:0] o_seq_ctr,
    output logic             o_seq_adv,
    output logic             o_seq_alu_cin,
    output logic             o_seq_reg_wr,
    output logic             o_seq_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic             carry_q, carry_d;
    logic             imm_q, imm_d;
    logic             wr_q, wr_d;
    logic             cin_q, cin_d;

    logic             busy;
    logic             adv;
    logic             last;
    logic             acp;
    logic             accept;

    assign busy   = (state_q != ST_IDLE);
    assign adv    = busy && (!imm_q || i_seq_imm_vld) && !i_seq_flush;
    assign last   = adv && (ctr_q == CTR_W'(N_NIB - 1));
    assign acp    = !i_seq_flush && (!busy || last);
    assign accept = i_seq_op_vld && acp;

    // Flush outranks accept, which outranks completion of the final nibble.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        carry_d = adv ? i_seq_alu_cout : carry_q;
        imm_d   = imm_q;
        wr_d    = wr_q;
        cin_d   = cin_q;
        if (i_seq_flush) begin
            state_d = ST_IDLE;
            ctr_d   = '0;
        end else if (accept) begin
            state_d = ST_EXEC;
            ctr_d   = '0;
            imm_d   = i_seq_imm_req;
            wr_d    = i_seq_wr_en;
            cin_d   = i_seq_cin_init;
        end else if (last) begin
            state_d = ST_IDLE;
            ctr_d   = '0;
        end else if (adv) begin
            state_d = ST_EXEC;
            ctr_d   = CTR_W'(ctr_q + 1'b1);
        end else if (busy) begin
            state_d = ST_STALL;
        end
    end

    always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            state_q <= ST_IDLE;
            ctr_q   <= '0;
            carry_q <= 1'b0;
            imm_q   <= 1'b0;
            wr_q    <= 1'b0;
            cin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            carry_q <= carry_d;
            imm_q   <= imm_d;
            wr_q    <= wr_d;
            cin_q   <= cin_d;
        end
    end

    assign o_seq_op_acp  = acp;
    assign o_seq_busy    = busy;
    assign o_seq_ctr     = ctr_q;
    assign o_seq_adv     = adv;
    assign o_seq_alu_cin = (ctr_q == '0) ? cin_q : carry_q;
    assign o_seq_reg_wr  = adv && wr_q;
    assign o_seq_done    = last;

    a_wr_busy : assert property (@(posedge i_ex_gck) disable iff (!i_ex_rst_n)
        o_seq_reg_wr |-> o_seq_busy);
    a_done_pulse : assert property (@(posedge i_ex_gck) disable iff (!i_ex_rst_n)
        (o_seq_done && !accept) |=> !o_seq_done);
    a_idle_ctr : assert property (@(posedge i_ex_gck) disable iff (!i_ex_rst_n)
        (state_q == ST_IDLE) |-> (ctr_q == '0));

endmodule

// File: tb/tb_idli_ex_seq_m.sv
// Scoreboard bench for idli_ex_seq_m: directed scenarios then random traffic,
// expected outputs pushed per cycle and checked by an independent monitor.
module tb_idli_ex_seq_m;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_vld, imm_req, wr_en, cin_init, imm_vld, cout, flush;
    logic       acp, busy, adv, alu_cin, reg_wr, done;
    logic [1:0] ctr;

    always #5 clk = ~clk;

    idli_ex_seq_m #(.N_NIB(N)) dut (
        .i_ex_gck      (clk),
        .i_ex_rst_n    (rst_n),
        .i_seq_op_vld  (op_vld),
        .o_seq_op_acp  (acp),
        .i_seq_imm_req (imm_req),
        .i_seq_wr_en   (wr_en),
        .i_seq_cin_init(cin_init),
        .i_seq_imm_vld (imm_vld),
        .i_seq_alu_cout(cout),
        .i_seq_flush   (flush),
        .o_seq_busy    (busy),
        .o_seq_ctr     (ctr),
        .o_seq_adv     (adv),
        .o_seq_alu_cin (alu_cin),
        .o_seq_reg_wr  (reg_wr),
        .o_seq_done    (done)
    );

    // {acp, busy, ctr[1:0], adv, alu_cin, reg_wr, done}
    logic [7:0] exp_q[$];
    int tests  = 0;
    int fails  = 0;
    int pushed = 0;
    int popped = 0;

    // Reference: an op is "in flight" with nib nibbles already finished.
    bit m_inflight = 0;
    int m_nib      = 0;
    bit m_imm = 0, m_wr = 0, m_cin = 0, m_carry = 0;

    task automatic step(input bit r_n, input bit vld, input bit imm, input bit wr,
                        input bit ci, input bit iv, input bit co, input bit fl);
        bit e_adv, e_last, e_acp, e_cin;
        @(negedge clk);
        rst_n = r_n; op_vld = vld; imm_req = imm; wr_en = wr; cin_init = ci;
        imm_vld = iv; cout = co; flush = fl;
        if (!r_n) begin
            m_inflight = 0; m_nib = 0; m_imm = 0; m_wr = 0; m_cin = 0; m_carry = 0;
        end
        e_adv  = m_inflight && (!m_imm || iv) && !fl;
        e_last = e_adv && (m_nib == N - 1);
        e_acp  = !fl && (!m_inflight || e_last);
        e_cin  = (m_nib == 0) ? m_cin : m_carry;
        #1;
        exp_q.push_back({e_acp, m_inflight, 2'(m_nib), e_adv, e_cin, e_adv && m_wr, e_last});
        pushed++;
        if (r_n) begin
            if (e_adv) m_carry = co;
            if (fl) begin
                m_inflight = 0; m_nib = 0;
            end else if (vld && e_acp) begin
                m_inflight = 1; m_nib = 0; m_imm = imm; m_wr = wr; m_cin = ci;
            end else if (e_last) begin
                m_inflight = 0; m_nib = 0;
            end else if (e_adv) begin
                m_nib = m_nib + 1;
            end
        end
    endtask

    // Idle cycle with no op offered.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        logic [7:0] got, want;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                popped++;
                got = {acp, busy, ctr, adv, alu_cin, reg_wr, done};
                tests++;
                if (got !== want) begin
                    fails++;
                    $display("FAIL outputs t=%0t got acp/busy/ctr/adv/cin/wr/done=%b/%b/%0d/%b/%b/%b/%b want %b/%b/%0d/%b/%b/%b/%b",
                             $time, got[7], got[6], got[5:4], got[3], got[2], got[1], got[0],
                             want[7], want[6], want[5:4], want[3], want[2], want[1], want[0]);
                end
            end
        end
    end

    initial begin : stim
        rst_n = 0; op_vld = 0; imm_req = 0; wr_en = 0; cin_init = 0;
        imm_vld = 0; cout = 0; flush = 0;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Single reg op, then reset asserted mid-op at ctr=2.
        step(1, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Single reg op to completion.
        step(1, 1, 0, 1, 0, 0, 0, 0);
        idle(6);

        // Back-to-back: op_vld held high for two ops.
        for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 0, 0, 0, 0);
        idle(4);

        // Imm stall at ctr=1 for 3 cycles, carry chain cin_init=1 with cout 1,0,1.
        step(1, 1, 1, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        idle(3);

        // Flush at ctr=2 together with op_vld, then a fresh op.
        step(1, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0, 1);
        step(1, 1, 0, 1, 1, 0, 0, 0);
        idle(6);

        // Flush on the final nibble with an op offered.
        step(1, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0, 0, 1, 1);
        idle(3);

        // Random traffic with occasional flush and rare reset.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 2) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 ($urandom_range(0, 24) == 0));
        end
        idle(2);

        @(negedge clk);
        #3;
        tests++;
        if (popped != pushed || exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain popped=%0d pushed=%0d", popped, pushed);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
